// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the clock phase monitor.
package clk_mon_pkg;

   localparam int unsigned CNT_W_DEF       = 16;
   localparam int unsigned SYNC_STAGES_DEF = 2;

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      DONE
   } state_e;

   typedef logic signed [CNT_W_DEF-1:0] res_s_t;

endpackage

// File: rtl/clk_phase_monitor_if.sv
// Control/result bundle of the clock phase monitor; slave side is the monitor.
interface clk_phase_monitor_if
   import clk_mon_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
);
   logic                    start;
   logic                    ref_clk;
   logic                    buf_clk;
   logic                    busy;
   logic                    done;
   logic                    timeout;
   logic        [CNT_W-1:0] ref_period;
   logic        [CNT_W-1:0] buf_period;
   logic signed [CNT_W-1:0] freq_diff;
   logic signed [CNT_W-1:0] phase_diff;

   modport master (
      output start, ref_clk, buf_clk,
      input  busy, done, timeout, ref_period, buf_period, freq_diff, phase_diff
   );

   modport slave (
      input  start, ref_clk, buf_clk,
      output busy, done, timeout, ref_period, buf_period, freq_diff, phase_diff
   );
endinterface

// File: rtl/clk_edge_det.sv
// Synchronizer plus rising-edge detector for one monitored clock.
// CLK_MON_SYNC_EN selects a SYNC_STAGES-deep synchronizer; otherwise a single register stage.
module clk_edge_det
   import clk_mon_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic mclk,
   input  logic rst_n,
   input  logic clk_in,
   output logic edge_c
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_stages
      $error("clk_edge_det: SYNC_STAGES must be 2 or 3");
   end

`ifdef CLK_MON_SYNC_EN
   localparam int unsigned NS = SYNC_STAGES;
`else
   localparam int unsigned NS = 1;
`endif

   logic [NS-1:0] sync_q, sync_d;
   logic          sync_prev_q, sync_prev_d;
   logic          sync_now;

   // Shift register: clk_in enters at bit 0, the synchronized level leaves at the top.
   always_comb begin
      sync_d      = NS'({sync_q, clk_in});
      sync_now    = sync_q[NS-1];
      sync_prev_d = sync_now;
      edge_c      = sync_now & ~sync_prev_q;
   end

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= '0;
         sync_prev_q <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         sync_prev_q <= sync_prev_d;
      end
   end

endmodule

// File: rtl/clk_phase_monitor.sv
// Measures ref/buf clock periods and their phase offset in mclk cycles.
// Build macro CLK_MON_SYNC_EN enables the multi-stage input synchronizers.
module clk_phase_monitor
   import clk_mon_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input logic                mclk,
   input logic                rst_n,
   clk_phase_monitor_if.slave bus
);

   localparam logic [CNT_W-1:0] TS_MAX = '1;

   state_e                  state_q, state_d;
   logic        [CNT_W-1:0] ts_q, ts_d;
   logic        [CNT_W-1:0] t1_q, t1_d, t2_q, t2_d, t4_q, t4_d, t5_q, t5_d;
   logic                    r1_q, r1_d, r2_q, r2_d, b1_q, b1_d, b2_q, b2_d;
   logic                    busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
   logic        [CNT_W-1:0] ref_period_q, ref_period_d, buf_period_q, buf_period_d;
   logic signed [CNT_W-1:0] freq_diff_q, freq_diff_d, phase_diff_q, phase_diff_d;
   logic                    ref_edge_c, buf_edge_c;

   clk_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_ref_det (
      .mclk   (mclk),
      .rst_n  (rst_n),
      .clk_in (bus.ref_clk),
      .edge_c (ref_edge_c)
   );

   clk_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_buf_det (
      .mclk   (mclk),
      .rst_n  (rst_n),
      .clk_in (bus.buf_clk),
      .edge_c (buf_edge_c)
   );

   always_comb begin
      state_d      = state_q;
      ts_d         = ts_q;
      t1_d         = t1_q;
      t2_d         = t2_q;
      t4_d         = t4_q;
      t5_d         = t5_q;
      r1_d         = r1_q;
      r2_d         = r2_q;
      b1_d         = b1_q;
      b2_d         = b2_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      timeout_d    = timeout_q;
      ref_period_d = ref_period_q;
      buf_period_d = buf_period_q;
      freq_diff_d  = freq_diff_q;
      phase_diff_d = phase_diff_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               ts_d    = '0;
               r1_d    = 1'b0;
               r2_d    = 1'b0;
               b1_d    = 1'b0;
               b2_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            ts_d = ts_q + CNT_W'(1);
            if (ref_edge_c) begin
               if (!r1_q) begin
                  t1_d = ts_q;
                  r1_d = 1'b1;
               end else if (!r2_q) begin
                  t2_d = ts_q;
                  r2_d = 1'b1;
               end
            end
            if (buf_edge_c) begin
               if (!b1_q) begin
                  t4_d = ts_q;
                  b1_d = 1'b1;
               end else if (!b2_q) begin
                  t5_d = ts_q;
                  b2_d = 1'b1;
               end
            end
            // Results use this cycle's captures so done lands one cycle after the last one.
            if (r2_d && b2_d) begin
               state_d      = DONE;
               done_d       = 1'b1;
               timeout_d    = 1'b0;
               ref_period_d = t2_d - t1_d;
               buf_period_d = t5_d - t4_d;
               freq_diff_d  = $signed(buf_period_d - ref_period_d);
               phase_diff_d = $signed(t4_d - t1_d);
            end else if (ts_q == TS_MAX) begin
               state_d      = DONE;
               done_d       = 1'b1;
               timeout_d    = 1'b1;
               ref_period_d = '0;
               buf_period_d = '0;
               freq_diff_d  = '0;
               phase_diff_d = '0;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ts_q         <= '0;
         t1_q         <= '0;
         t2_q         <= '0;
         t4_q         <= '0;
         t5_q         <= '0;
         r1_q         <= 1'b0;
         r2_q         <= 1'b0;
         b1_q         <= 1'b0;
         b2_q         <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         ref_period_q <= '0;
         buf_period_q <= '0;
         freq_diff_q  <= '0;
         phase_diff_q <= '0;
      end else begin
         state_q      <= state_d;
         ts_q         <= ts_d;
         t1_q         <= t1_d;
         t2_q         <= t2_d;
         t4_q         <= t4_d;
         t5_q         <= t5_d;
         r1_q         <= r1_d;
         r2_q         <= r2_d;
         b1_q         <= b1_d;
         b2_q         <= b2_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
         ref_period_q <= ref_period_d;
         buf_period_q <= buf_period_d;
         freq_diff_q  <= freq_diff_d;
         phase_diff_q <= phase_diff_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.timeout    = timeout_q;
   assign bus.ref_period = ref_period_q;
   assign bus.buf_period = buf_period_q;
   assign bus.freq_diff  = freq_diff_q;
   assign bus.phase_diff = phase_diff_q;

endmodule

// File: tb/tb_clk_phase_monitor.sv
// Directed and randomized bench for clk_phase_monitor (16-bit and 8-bit instances).
module tb_clk_phase_monitor;
   import clk_mon_pkg::*;

`ifdef CLK_MON_SYNC_EN
   localparam int LAT = int'(SYNC_STAGES_DEF) + 1;
`else
   localparam int LAT = 2;
`endif

   logic mclk    = 1'b0;
   logic rst_n   = 1'b0;
   logic ref_clk = 1'b0;
   logic buf_clk = 1'b0;
   logic start16 = 1'b0;
   logic start8  = 1'b0;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   bit ref_en = 1'b0;
   bit buf_en = 1'b0;
   int ref_per = 16, buf_per = 16, ref_t0 = 0, buf_t0 = 0;

   always #5 mclk = ~mclk;
   always @(posedge mclk) cyc <= cyc + 1;

   // Waveform generators: first rising edge at cycle t0, then every per cycles.
   always @(negedge mclk) begin
      ref_clk = (ref_en && cyc >= ref_t0) ? (((cyc - ref_t0) % ref_per) < (ref_per / 2)) : 1'b0;
      buf_clk = (buf_en && cyc >= buf_t0) ? (((cyc - buf_t0) % buf_per) < (buf_per / 2)) : 1'b0;
   end

   clk_phase_monitor_if #(.CNT_W(16)) bus16 ();
   clk_phase_monitor_if #(.CNT_W(8))  bus8 ();

   assign bus16.ref_clk = ref_clk;
   assign bus16.buf_clk = buf_clk;
   assign bus16.start   = start16;
   assign bus8.ref_clk  = ref_clk;
   assign bus8.buf_clk  = 1'b0;
   assign bus8.start    = start8;

   clk_phase_monitor #(.CNT_W(16), .SYNC_STAGES(2)) dut16 (
      .mclk  (mclk),
      .rst_n (rst_n),
      .bus   (bus16.slave)
   );

   clk_phase_monitor #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
      .mclk  (mclk),
      .rst_n (rst_n),
      .bus   (bus8.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_done16(input int budget, output int dcyc, output bit ok);
      ok   = 1'b0;
      dcyc = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge mclk);
         if (bus16.done === 1'b1) begin
            ok   = 1'b1;
            dcyc = cyc;
            break;
         end
      end
   endtask

   task automatic quiet_clocks();
      ref_en = 1'b0;
      buf_en = 1'b0;
      repeat (6) @(negedge mclk);
   endtask

   task automatic pulse_start16(output int s);
      @(negedge mclk);
      start16 = 1'b1;
      s       = cyc;
      @(negedge mclk);
      start16 = 1'b0;
   endtask

   // One measurement on the 16-bit monitor; expectations come from the generated edge times.
   task automatic run_meas(input int pr, input int pb, input int dr, input int db, input bit extra);
      int s, dcyc, exp_done, r2, b2;
      bit ok;
      quiet_clocks();
      pulse_start16(s);
      chk("busy_after_start", 32'(bus16.busy), 32'd1);
      ref_per = pr;
      buf_per = pb;
      ref_t0  = s + 2 + dr;
      buf_t0  = s + 2 + db;
      ref_en  = 1'b1;
      buf_en  = 1'b1;
      r2 = ref_t0 + pr;
      b2 = buf_t0 + pb;
      exp_done = ((r2 > b2) ? r2 : b2) + LAT;
      if (extra) begin
         repeat (4) @(negedge mclk);
         chk("busy_at_second_start", 32'(bus16.busy), 32'd1);
         start16 = 1'b1;
         @(negedge mclk);
         start16 = 1'b0;
      end
      wait_done16(2000, dcyc, ok);
      chk("done_seen", 32'(ok), 32'd1);
      chk("done_cycle", 32'(dcyc), 32'(exp_done));
      chk("timeout", 32'(bus16.timeout), 32'd0);
      chk("ref_period", 32'(bus16.ref_period), 32'(pr));
      chk("buf_period", 32'(bus16.buf_period), 32'(pb));
      chk("freq_diff", 32'($unsigned(bus16.freq_diff)), 32'($unsigned(16'(pb - pr))));
      chk("phase_diff", 32'($unsigned(bus16.phase_diff)), 32'($unsigned(16'(db - dr))));
      @(negedge mclk);
      chk("done_one_cycle", 32'(bus16.done), 32'd0);
      chk("busy_fall", 32'(bus16.busy), 32'd0);
   endtask

   initial begin
      int s, dcyc, ndone;
      bit ok;

      repeat (3) @(negedge mclk);
      chk("rst_busy", 32'(bus16.busy), 32'd0);
      chk("rst_done", 32'(bus16.done), 32'd0);
      chk("rst_timeout", 32'(bus16.timeout), 32'd0);
      chk("rst_ref_period", 32'(bus16.ref_period), 32'd0);
      chk("rst_phase_diff", 32'($unsigned(bus16.phase_diff)), 32'd0);
      rst_n = 1'b1;

      run_meas(16, 16, 0, 3, 1'b0);
      run_meas(16, 20, 0, 0, 1'b0);
      run_meas(16, 16, 5, 0, 1'b0);
      chk("phase_lead_hex", 32'($unsigned(bus16.phase_diff)), 32'h0000_FFFB);

      // 8-bit instance with buf_clk stuck low must time out after 256 cycles.
      ref_per = 16;
      ref_t0  = cyc + 2;
      ref_en  = 1'b1;
      @(negedge mclk);
      start8 = 1'b1;
      s      = cyc;
      @(negedge mclk);
      start8 = 1'b0;
      chk("t8_busy", 32'(bus8.busy), 32'd1);
      ok = 1'b0;
      dcyc = -1;
      for (int i = 0; i < 400; i++) begin
         if (bus8.done === 1'b1) begin
            ok   = 1'b1;
            dcyc = cyc;
            break;
         end
         @(negedge mclk);
      end
      chk("t8_done_seen", 32'(ok), 32'd1);
      chk("t8_latency", 32'(dcyc - (s + 1)), 32'd256);
      chk("t8_timeout", 32'(bus8.timeout), 32'd1);
      chk("t8_ref_period", 32'(bus8.ref_period), 32'd0);
      chk("t8_buf_period", 32'(bus8.buf_period), 32'd0);
      chk("t8_freq_diff", 32'($unsigned(bus8.freq_diff)), 32'd0);
      chk("t8_phase_diff", 32'($unsigned(bus8.phase_diff)), 32'd0);

      // Reset after t1 is captured: outputs clear at once, no done follows.
      quiet_clocks();
      pulse_start16(s);
      ref_per = 40;
      buf_per = 40;
      ref_t0  = s + 2;
      buf_t0  = s + 32;
      ref_en  = 1'b1;
      buf_en  = 1'b1;
      while (cyc < ref_t0 + LAT + 2) @(negedge mclk);
      chk("pre_rst_busy", 32'(bus16.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(bus16.busy), 32'd0);
      chk("mid_rst_done", 32'(bus16.done), 32'd0);
      chk("mid_rst_ref_period", 32'(bus16.ref_period), 32'd0);
      chk("mid_rst_phase_diff", 32'($unsigned(bus16.phase_diff)), 32'd0);
      @(negedge mclk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (150) begin
         @(negedge mclk);
         if (bus16.done === 1'b1) ndone++;
      end
      chk("no_done_after_rst", 32'(ndone), 32'd0);
      run_meas(12, 12, 2, 7, 1'b0);

      // Second start while busy must not restart the measurement.
      run_meas(16, 16, 0, 3, 1'b1);
      ndone = 0;
      repeat (100) begin
         @(negedge mclk);
         if (bus16.done === 1'b1) ndone++;
      end
      chk("single_done", 32'(ndone), 32'd0);

      for (int k = 0; k < 6; k++) begin
         run_meas(int'($urandom_range(40, 4)), int'($urandom_range(40, 4)),
                  int'($urandom_range(30, 0)), int'($urandom_range(30, 0)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
